// File: rtl/mem_stage_lsu.sv
// Memory stage for the veriRISCV pipeline. It formats load data, waits for
// variable-latency load responses while stalling upstream, faults a load
// that never gets a response, and throws away orphaned responses left
// behind by a flush or a timeout.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic            lsu_readdatavalid,
  input  logic [XLEN-1:0] lsu_readdata,
  output logic            mem_busy,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_pc,
  output logic [XLEN-1:0] wb_writedata,
  output logic            wb_exc_load_fault
);

  localparam int OFF_W = $clog2(XLEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_pending_q, drop_pending_d;

  // Load being waited on; EX/MEM is stalled anyway, but a private copy keeps
  // the formatting independent of what upstream presents meanwhile.
  logic [2:0]       pend_funct3_q, pend_funct3_d;
  logic [OFF_W-1:0] pend_off_q, pend_off_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic             pend_reg_write_q, pend_reg_write_d;

  // Completed result parked while the downstream stage is stalled.
  logic             hold_reg_write_q, hold_reg_write_d;
  logic [4:0]       hold_rd_q, hold_rd_d;
  logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]  hold_data_q, hold_data_d;
  logic             hold_fault_q, hold_fault_d;

  // MEM/WB pipeline register.
  logic             wb_valid_q, wb_valid_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_pc_q, wb_pc_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             wb_fault_q, wb_fault_d;

  // Result that finishes this cycle (load data or timeout fault).
  logic             complete;
  logic             res_reg_write;
  logic [4:0]       res_rd;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  res_data;
  logic             res_fault;

  logic is_load;
  logic resp_live;
  logic resp_drop;

  // Select the addressed byte lane and extend to XLEN; LD/LWU exist only on RV64.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]       f3,
                                               input logic [OFF_W-1:0] off,
                                               input logic [XLEN-1:0]  word);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    fmt_load = '0;
    case (f3)
      3'b000: fmt_load = XLEN'($signed(sh[7:0]));
      3'b001: fmt_load = XLEN'($signed(sh[15:0]));
      3'b010: fmt_load = XLEN'($signed(sh[31:0]));
      3'b011: if (XLEN == 64) fmt_load = sh;
      3'b100: fmt_load = XLEN'(sh[7:0]);
      3'b101: fmt_load = XLEN'(sh[15:0]);
      3'b110: if (XLEN == 64) fmt_load = XLEN'(sh[31:0]);
      default: fmt_load = '0;
    endcase
  endfunction

  assign is_load   = ex_valid & ex_mem_read;
  assign resp_live = lsu_readdatavalid & ~drop_pending_q;
  assign resp_drop = lsu_readdatavalid & drop_pending_q;

  // Upstream stall: busy while a load is in flight or a new load lacks its data.
  assign mem_busy = (state_q != S_IDLE) | (is_load & ~resp_live);

  // Next-state, orphan tracking and MEM/WB update.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    drop_pending_d   = drop_pending_q;
    pend_funct3_d    = pend_funct3_q;
    pend_off_d       = pend_off_q;
    pend_rd_d        = pend_rd_q;
    pend_pc_d        = pend_pc_q;
    pend_reg_write_d = pend_reg_write_q;
    hold_reg_write_d = hold_reg_write_q;
    hold_rd_d        = hold_rd_q;
    hold_pc_d        = hold_pc_q;
    hold_data_d      = hold_data_q;
    hold_fault_d     = hold_fault_q;
    wb_valid_d       = wb_valid_q;
    wb_reg_write_d   = wb_reg_write_q;
    wb_rd_d          = wb_rd_q;
    wb_pc_d          = wb_pc_q;
    wb_data_d        = wb_data_q;
    wb_fault_d       = wb_fault_q;
    complete         = 1'b0;
    res_reg_write    = 1'b0;
    res_rd           = '0;
    res_pc           = '0;
    res_data         = '0;
    res_fault        = 1'b0;

    // An orphaned response is swallowed here, whatever state we are in.
    if (resp_drop) drop_pending_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          if (resp_live) begin
            complete      = 1'b1;
            res_reg_write = ex_reg_write;
            res_rd        = ex_rd;
            res_pc        = ex_pc;
            res_data      = fmt_load(ex_funct3, ex_alu_out[OFF_W-1:0], lsu_readdata);
          end else begin
            state_d          = S_WAIT;
            cnt_d            = '0;
            pend_funct3_d    = ex_funct3;
            pend_off_d       = ex_alu_out[OFF_W-1:0];
            pend_rd_d        = ex_rd;
            pend_pc_d        = ex_pc;
            pend_reg_write_d = ex_reg_write;
            if (!stall_in) begin
              wb_valid_d     = 1'b0;
              wb_reg_write_d = 1'b0;
              wb_fault_d     = 1'b0;
            end
          end
        end else if (!stall_in) begin
          wb_valid_d     = ex_valid;
          wb_reg_write_d = ex_valid & ex_reg_write;
          wb_rd_d        = ex_rd;
          wb_pc_d        = ex_pc;
          wb_data_d      = ex_alu_out;
          wb_fault_d     = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (resp_live) begin
          complete      = 1'b1;
          res_reg_write = pend_reg_write_q;
          res_rd        = pend_rd_q;
          res_pc        = pend_pc_q;
          res_data      = fmt_load(pend_funct3_q, pend_off_q, lsu_readdata);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // The response may still turn up later; mark it as an orphan.
          complete       = 1'b1;
          res_rd         = pend_rd_q;
          res_pc         = pend_pc_q;
          res_fault      = 1'b1;
          drop_pending_d = 1'b1;
        end else if (!stall_in) begin
          wb_valid_d     = 1'b0;
          wb_reg_write_d = 1'b0;
          wb_fault_d     = 1'b0;
        end
      end
      S_DONE: begin
        if (!stall_in) begin
          state_d        = S_IDLE;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = hold_reg_write_q;
          wb_rd_d        = hold_rd_q;
          wb_pc_d        = hold_pc_q;
          wb_data_d      = hold_data_q;
          wb_fault_d     = hold_fault_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      if (stall_in) begin
        state_d          = S_DONE;
        hold_reg_write_d = res_reg_write;
        hold_rd_d        = res_rd;
        hold_pc_d        = res_pc;
        hold_data_d      = res_data;
        hold_fault_d     = res_fault;
      end else begin
        state_d        = S_IDLE;
        wb_valid_d     = 1'b1;
        wb_reg_write_d = res_reg_write;
        wb_rd_d        = res_rd;
        wb_pc_d        = res_pc;
        wb_data_d      = res_data;
        wb_fault_d     = res_fault;
      end
    end

    // Flush wins; a load killed while waiting leaves its response outstanding.
    if (flush) begin
      state_d        = S_IDLE;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_fault_d     = 1'b0;
      if (state_q == S_WAIT && !resp_live) drop_pending_d = 1'b1;
    end
  end

  // FSM state, timeout counter and orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      drop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drop_pending_q <= drop_pending_d;
    end
  end

  // Pending-load copy, hold buffer and MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_funct3_q    <= '0;
      pend_off_q       <= '0;
      pend_rd_q        <= '0;
      pend_pc_q        <= '0;
      pend_reg_write_q <= 1'b0;
      hold_reg_write_q <= 1'b0;
      hold_rd_q        <= '0;
      hold_pc_q        <= '0;
      hold_data_q      <= '0;
      hold_fault_q     <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_rd_q          <= '0;
      wb_pc_q          <= '0;
      wb_data_q        <= '0;
      wb_fault_q       <= 1'b0;
    end else begin
      pend_funct3_q    <= pend_funct3_d;
      pend_off_q       <= pend_off_d;
      pend_rd_q        <= pend_rd_d;
      pend_pc_q        <= pend_pc_d;
      pend_reg_write_q <= pend_reg_write_d;
      hold_reg_write_q <= hold_reg_write_d;
      hold_rd_q        <= hold_rd_d;
      hold_pc_q        <= hold_pc_d;
      hold_data_q      <= hold_data_d;
      hold_fault_q     <= hold_fault_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_rd_q          <= wb_rd_d;
      wb_pc_q          <= wb_pc_d;
      wb_data_q        <= wb_data_d;
      wb_fault_q       <= wb_fault_d;
    end
  end

  assign wb_valid          = wb_valid_q;
  assign wb_reg_write      = wb_reg_write_q;
  assign wb_rd             = wb_rd_q;
  assign wb_pc             = wb_pc_q;
  assign wb_writedata      = wb_data_q;
  assign wb_exc_load_fault = wb_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, TIMEOUT=16).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        flush;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_out;
  logic        lsu_readdatavalid;
  logic [31:0] lsu_readdata;
  logic        mem_busy;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_pc;
  logic [31:0] wb_writedata;
  logic        wb_exc_load_fault;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
    .lsu_readdatavalid(lsu_readdatavalid), .lsu_readdata(lsu_readdata),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_writedata(wb_writedata),
    .wb_exc_load_fault(wb_exc_load_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] data, input logic fault);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(v));
    chk({tag, ".reg_write"}, 64'(wb_reg_write), 64'(rw));
    chk({tag, ".rd"}, 64'(wb_rd), 64'(rd));
    chk({tag, ".pc"}, 64'(wb_pc), 64'(pc));
    chk({tag, ".data"}, 64'(wb_writedata), 64'(data));
    chk({tag, ".fault"}, 64'(wb_exc_load_fault), 64'(fault));
    $display("txn %s: valid=%0d rw=%0d rd=%0d pc=0x%08h data=0x%08h fault=%0d",
             tag, wb_valid, wb_reg_write, wb_rd, wb_pc, wb_writedata, wb_exc_load_fault);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_funct3 = 0;
    lsu_readdatavalid = 0; lsu_readdata = 0; flush = 0;
  endtask

  task automatic put_alu(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu);
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 0; ex_funct3 = 0;
    ex_rd = rd; ex_pc = pc; ex_alu_out = alu;
  endtask

  task automatic put_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] addr);
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_funct3 = f3;
    ex_rd = rd; ex_pc = pc; ex_alu_out = addr;
  endtask

  task automatic respond(input logic [31:0] data);
    lsu_readdatavalid = 1; lsu_readdata = data;
  endtask

  logic [2:0]  fv_f3   [7] = '{3'b100, 3'b000, 3'b101, 3'b010, 3'b011, 3'b001, 3'b100};
  logic [31:0] fv_addr [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000, 32'h1001, 32'h1000};
  logic [31:0] fv_data [7] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_0000, 32'h80FF_1234,
                               32'h1111_2222, 32'h00FF_7F00, 32'h80FF_1234};
  logic [31:0] fv_exp  [7] = '{32'h0000_0080, 32'hFFFF_FF80, 32'h0000_8001, 32'h80FF_1234,
                               32'h0000_0000, 32'hFFFF_FF7F, 32'h0000_0034};

  initial begin
    rst_n = 0; stall_in = 0; ex_rd = 0; ex_pc = 0; ex_alu_out = 0;
    go_idle();
    #3;
    chk_wb("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.busy_idle", 64'(mem_busy), 64'd0);
    put_load(3'b010, 1, 32'h0, 32'h0);
    #1;
    chk("reset.busy_comb", 64'(mem_busy), 64'd1);
    go_idle();
    @(posedge clk); #1; rst_n = 1;

    // Plain ALU pass-through, stall hold, flush priority.
    put_alu(5, 32'h100, 32'hDEAD_BEEF);
    step();
    chk_wb("alu", 1, 1, 5, 32'h100, 32'hDEAD_BEEF, 0);
    stall_in = 1; put_alu(6, 32'h104, 32'h1111_1111);
    step();
    chk_wb("alu_stall_hold", 1, 1, 5, 32'h100, 32'hDEAD_BEEF, 0);
    stall_in = 0; flush = 1;
    step();
    chk("flush.valid", 64'(wb_valid), 64'd0);
    chk("flush.reg_write", 64'(wb_reg_write), 64'd0);
    flush = 0;

    // Same-cycle responses through the formatter.
    for (int i = 0; i < 7; i++) begin
      put_load(fv_f3[i], 5'(6 + i), 32'h104 + 32'(4 * i), fv_addr[i]);
      respond(fv_data[i]);
      #1;
      chk($sformatf("fmt%0d.busy", i), 64'(mem_busy), 64'd0);
      step();
      chk_wb($sformatf("fmt%0d", i), 1, 1, 5'(6 + i), 32'h104 + 32'(4 * i), fv_exp[i], 0);
    end
    go_idle();
    #1;
    chk("fmt.busy_after", 64'(mem_busy), 64'd0);
    step();
    chk("nop.valid", 64'(wb_valid), 64'd0);

    // LH answered three cycles late.
    put_load(3'b001, 11, 32'h200, 32'h2002);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) respond(32'h8001_0000);
      #1;
      chk($sformatf("late.busy%0d", k), 64'(mem_busy), 64'd1);
      step();
      if (k < 3) chk($sformatf("late.bubble%0d", k), 64'(wb_valid), 64'd0);
    end
    chk_wb("late", 1, 1, 11, 32'h200, 32'hFFFF_8001, 0);
    go_idle();
    #1;
    chk("late.busy_after", 64'(mem_busy), 64'd0);

    // LW that never gets a response: fault on the 16th waiting cycle.
    put_load(3'b010, 12, 32'h300, 32'h3000);
    step();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("tmo.nofault%0d", k), 64'(wb_exc_load_fault), 64'd0);
      chk($sformatf("tmo.busy%0d", k), 64'(mem_busy), 64'd1);
      step();
    end
    chk("tmo.nofault16", 64'(wb_exc_load_fault), 64'd0);
    step();
    chk_wb("timeout", 1, 0, 12, 32'h300, 32'h0, 1);
    // Late response lands with the next load: must be discarded.
    put_load(3'b010, 13, 32'h304, 32'h3004);
    respond(32'hDEAD_0000);
    #1;
    chk("orphan.busy", 64'(mem_busy), 64'd1);
    step();
    chk("orphan.bubble", 64'(wb_valid), 64'd0);
    chk("orphan.fault_clr", 64'(wb_exc_load_fault), 64'd0);
    respond(32'hCAFE_F00D);
    step();
    chk_wb("after_orphan", 1, 1, 13, 32'h304, 32'hCAFE_F00D, 0);
    go_idle();
    step();

    // Flush in the second waiting cycle, then stale + real response.
    put_load(3'b010, 14, 32'h400, 32'h4000);
    step();
    step();
    flush = 1;
    step();
    go_idle();
    #1;
    chk("flushwait.valid", 64'(wb_valid), 64'd0);
    chk("flushwait.busy", 64'(mem_busy), 64'd0);
    put_load(3'b010, 15, 32'h404, 32'h4004);
    respond(32'hBAD0_BAD0);
    #1;
    chk("stale.busy", 64'(mem_busy), 64'd1);
    step();
    chk("stale.bubble", 64'(wb_valid), 64'd0);
    respond(32'h1234_5678);
    step();
    chk_wb("after_stale", 1, 1, 15, 32'h404, 32'h1234_5678, 0);
    go_idle();
    step();

    // Response while downstream stalled for three cycles.
    put_load(3'b010, 16, 32'h500, 32'h5000);
    step();
    stall_in = 1; respond(32'h55AA_33CC);
    step();
    lsu_readdatavalid = 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done.hold%0d", k), 64'(wb_valid), 64'd0);
      chk($sformatf("done.busy%0d", k), 64'(mem_busy), 64'd1);
      step();
    end
    chk("done.hold2", 64'(wb_valid), 64'd0);
    stall_in = 0;
    #1;
    chk("done.busy_release", 64'(mem_busy), 64'd1);
    step();
    chk_wb("done", 1, 1, 16, 32'h500, 32'h55AA_33CC, 0);
    go_idle();
    #1;
    chk("done.busy_after", 64'(mem_busy), 64'd0);

    // Asynchronous reset mid-WAIT with an orphan pending.
    put_alu(17, 32'h600, 32'hA5A5_A5A5);
    step();
    stall_in = 1; put_load(3'b010, 18, 32'h604, 32'h6000);
    step();
    chk("rst.held_pc", 64'(wb_pc), 64'h600);
    stall_in = 0; flush = 1;
    step();
    flush = 0; put_load(3'b010, 19, 32'h608, 32'h6008);
    step();
    chk("rst.pre_data", 64'(wb_writedata), 64'hA5A5_A5A5);
    #2;
    rst_n = 0; go_idle();
    #1;
    chk_wb("async_reset", 0, 0, 0, 0, 0, 0);
    chk("rst.busy", 64'(mem_busy), 64'd0);
    @(posedge clk); #1; rst_n = 1;
    put_load(3'b100, 20, 32'h700, 32'h7001);
    respond(32'h0000_AB00);
    #1;
    chk("rst.nodrop_busy", 64'(mem_busy), 64'd0);
    step();
    chk_wb("post_reset", 1, 1, 20, 32'h700, 32'h0000_00AB, 0);
    go_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
